// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline definitions: stall-FSM state encoding, default mul/div
// latency and the forwarding-unit select codes.
package pipeline_stall_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   localparam int MD_CYCLES_DEFAULT = 8;

   typedef enum logic [1:0] {
      FWD_ID_EX  = 2'b00,
      FWD_MEM_WB = 2'b01,
      FWD_EX_MEM = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/pipeline_stall_ctrl_load_use.sv
// Combinational load-use comparator between the EX load destination and the
// ID source registers; register 0 never creates a hazard.
module load_use_detect
   (
      input  logic [4:0] id_rs,
      input  logic [4:0] id_rt,
      input  logic       id_uses_rs,
      input  logic       id_uses_rt,
      input  logic       ex_mem_read,
      input  logic [4:0] ex_reg,
      output logic       hazard
   );

   logic rs_match;
   logic rt_match;

   assign rs_match = id_uses_rs && (ex_reg == id_rs);
   assign rt_match = id_uses_rt && (ex_reg == id_rt);
   assign hazard   = ex_mem_read && (ex_reg != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubble, branch flush, optional
// multi-cycle mul/div stall (macro MULDIV_STALL_EN) and saturating stall counter.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
   #(
      parameter int MD_CYCLES = MD_CYCLES_DEFAULT
   )
   (
      input  logic        Clk,
      input  logic        Rst_n,
      input  logic [4:0]  ID_rs,
      input  logic [4:0]  ID_rt,
      input  logic        ID_UsesRs,
      input  logic        ID_UsesRt,
      input  logic        EX_MemRead,
      input  logic [4:0]  EX_Reg,
      input  logic        EX_BrTaken,
      input  logic        EX_MulDiv,
      input  logic        Cnt_Clr,
      output logic        PC_Wr,
      output logic        IFID_Wr,
      output logic        IDEX_Wr,
      output logic        IFID_Flush,
      output logic        IDEX_Flush,
      output logic        EXMEM_Flush,
      output logic        MD_Busy,
      output logic [15:0] Stall_Cnt
   );

   logic        load_use;
   logic        md_stall;
   logic [15:0] stall_cnt_reg;

   load_use_detect u_load_use (
      .id_rs       (ID_rs),
      .id_rt       (ID_rt),
      .id_uses_rs  (ID_UsesRs),
      .id_uses_rt  (ID_UsesRt),
      .ex_mem_read (EX_MemRead),
      .ex_reg      (EX_Reg),
      .hazard      (load_use)
   );

`ifdef MULDIV_STALL_EN
   // The issue cycle is stalled too, so MD_WAIT only needs MD_CYCLES-2 more.
   localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);

   state_t     state_reg, state_next;
   logic [3:0] md_cnt_reg, md_cnt_next;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg  <= RUN;
         md_cnt_reg <= 4'd0;
      end else begin
         state_reg  <= state_next;
         md_cnt_reg <= md_cnt_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      md_cnt_next = md_cnt_reg;
      md_stall    = 1'b0;
      if (state_reg == RUN) begin
         if (EX_MulDiv) begin
            md_stall    = 1'b1;
            md_cnt_next = MD_LOAD;
            state_next  = MD_WAIT;
         end
      end else if (md_cnt_reg != 4'd0) begin
         md_stall    = 1'b1;
         md_cnt_next = md_cnt_reg - 4'd1;
      end else begin
         state_next = RUN;
      end
   end

   assign MD_Busy = (state_reg == MD_WAIT);
`else
   logic unused_muldiv;

   assign unused_muldiv = ^{EX_MulDiv, 4'(MD_CYCLES)};
   assign md_stall      = 1'b0;
   assign MD_Busy       = 1'b0;
`endif

   // Priority: mul/div stall, then taken branch (wrong-path load-use ignored), then load-use.
   always_comb begin
      PC_Wr       = 1'b1;
      IFID_Wr     = 1'b1;
      IDEX_Wr     = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Flush  = 1'b0;
      EXMEM_Flush = 1'b0;
      if (md_stall) begin
         PC_Wr       = 1'b0;
         IFID_Wr     = 1'b0;
         IDEX_Wr     = 1'b0;
         EXMEM_Flush = 1'b1;
      end else if (EX_BrTaken) begin
         IFID_Flush = 1'b1;
         IDEX_Flush = 1'b1;
      end else if (load_use) begin
         PC_Wr      = 1'b0;
         IFID_Wr    = 1'b0;
         IDEX_Flush = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         stall_cnt_reg <= 16'd0;
      end else if (Cnt_Clr) begin
         stall_cnt_reg <= 16'd0;
      end else if (!PC_Wr && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign Stall_Cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl against a cycle-position model
// of the stall rules; mul/div checks follow macro MULDIV_STALL_EN.
module tb_pipeline_stall_ctrl;

   localparam int MDC = 8;
`ifdef MULDIV_STALL_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif
   localparam logic [6:0] DEF = 7'b1110000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, ex_reg;
   logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_br_taken, ex_mul_div, cnt_clr;
   logic        pc_wr, ifid_wr, idex_wr, ifid_flush, idex_flush, exmem_flush, md_busy;
   logic [15:0] stall_cnt;
   logic [6:0]  dut_o;

   int          pass_count  = 0;
   int          check_count = 0;
   int          md_pos      = 0;
   logic [15:0] model_cnt   = 16'd0;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.MD_CYCLES(MDC)) dut (
      .Clk(clk), .Rst_n(rst_n),
      .ID_rs(id_rs), .ID_rt(id_rt), .ID_UsesRs(id_uses_rs), .ID_UsesRt(id_uses_rt),
      .EX_MemRead(ex_mem_read), .EX_Reg(ex_reg), .EX_BrTaken(ex_br_taken),
      .EX_MulDiv(ex_mul_div), .Cnt_Clr(cnt_clr),
      .PC_Wr(pc_wr), .IFID_Wr(ifid_wr), .IDEX_Wr(idex_wr),
      .IFID_Flush(ifid_flush), .IDEX_Flush(idex_flush), .EXMEM_Flush(exmem_flush),
      .MD_Busy(md_busy), .Stall_Cnt(stall_cnt)
   );

   assign dut_o = {pc_wr, ifid_wr, idex_wr, ifid_flush, idex_flush, exmem_flush, md_busy};

   // Model: p is this cycle's position (1..MDC) of a mul/div inside EX, 0 if none.
   function automatic logic [6:0] model_out(output int np);
      int   p;
      logic haz;
      logic [6:0] o;
      p = 0;
      if (MD_EN) begin
         if (md_pos > 0) p = md_pos + 1;
         else if (ex_mul_div) p = 1;
      end
      haz = ex_mem_read && (ex_reg != 0) &&
            ((id_uses_rs && ex_reg == id_rs) || (id_uses_rt && ex_reg == id_rt));
      o = DEF;
      if (p >= 2) o[0] = 1'b1;
      if (p >= 1 && p <= MDC - 1) begin
         o[6:4] = 3'b000;
         o[1]   = 1'b1;
      end else if (ex_br_taken) begin
         o[3] = 1'b1;
         o[2] = 1'b1;
      end else if (haz) begin
         o[6] = 1'b0;
         o[5] = 1'b0;
         o[2] = 1'b1;
      end
      np = (p >= 1 && p <= MDC - 1) ? p : 0;
      return o;
   endfunction

   task automatic set_idle();
      id_rs = 0; id_rt = 0; ex_reg = 0;
      id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
      ex_br_taken = 0; ex_mul_div = 0; cnt_clr = 0;
   endtask

   task automatic set_hazard();
      ex_mem_read = 1; ex_reg = 5; id_rs = 5; id_uses_rs = 1;
   endtask

   // Advance one clock, updating the model from the inputs applied this cycle.
   task automatic tick();
      logic [6:0] o;
      int np;
      o = model_out(np);
      @(posedge clk);
      md_pos = np;
      if (cnt_clr) model_cnt = 16'd0;
      else if (!o[6] && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      #1;
   endtask

   task automatic test_reset();
      set_idle();
      rst_n = 1'b0;
      #3;
      check_count++;
      if (dut_o !== DEF || stall_cnt !== 16'd0)
         $display("FAIL reset: outputs %b cnt %h, want %b cnt 0000", dut_o, stall_cnt, DEF);
      else pass_count++;
      @(negedge clk);
      rst_n = 1'b1;
      md_pos = 0; model_cnt = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_load_use();
      set_idle(); set_hazard();
      #3;
      check_count++;
      if (dut_o !== 7'b0010100) $display("FAIL load_use_out: got %b want 0010100", dut_o);
      else pass_count++;
      tick();
      set_idle();
      #3;
      check_count++;
      if (stall_cnt !== 16'd1 || dut_o !== DEF)
         $display("FAIL load_use_after: cnt %h out %b, want cnt 0001 out %b", stall_cnt, dut_o, DEF);
      else pass_count++;
      tick();
   endtask

   task automatic test_zero_reg();
      set_idle(); set_hazard(); ex_reg = 0; id_rs = 0;
      #3;
      check_count++;
      if (dut_o !== DEF) $display("FAIL zero_reg: got %b want %b", dut_o, DEF);
      else pass_count++;
      tick();
      check_count++;
      if (stall_cnt !== 16'd1) $display("FAIL zero_reg_cnt: got %h want 0001", stall_cnt);
      else pass_count++;
   endtask

   task automatic test_branch_load_use();
      set_idle(); set_hazard(); ex_br_taken = 1;
      #3;
      check_count++;
      if (dut_o !== 7'b1111100) $display("FAIL branch_load_use: got %b want 1111100", dut_o);
      else pass_count++;
      tick();
      set_idle();
      check_count++;
      if (stall_cnt !== 16'd1) $display("FAIL branch_cnt: got %h want 0001", stall_cnt);
      else pass_count++;
   endtask

   task automatic test_muldiv();
      logic [15:0] start;
      logic [6:0]  exp;
      set_idle();
      start = stall_cnt;
      ex_mul_div = 1;
      for (int k = 0; k < MDC; k++) begin
         #3;
         if (MD_EN) exp = {k > 6, k > 6, k > 6, 1'b0, 1'b0, k <= 6, k >= 1};
         else exp = DEF;
         check_count++;
         if (dut_o !== exp) $display("FAIL muldiv_t%0d: got %b want %b", k, dut_o, exp);
         else pass_count++;
         tick();
      end
      ex_mul_div = 0;
      #3;
      check_count++;
      if (dut_o !== DEF || stall_cnt !== start + (MD_EN ? 16'd7 : 16'd0))
         $display("FAIL muldiv_end: out %b cnt %h, want %b cnt %h", dut_o, stall_cnt, DEF,
                  start + (MD_EN ? 16'd7 : 16'd0));
      else pass_count++;
      tick();
   endtask

   task automatic test_reset_mid_stall();
      set_idle();
      ex_mul_div = 1;
      repeat (3) tick();
      #1;
      rst_n = 1'b0;
      md_pos = 0; model_cnt = 0;
      #1;
      check_count++;
      if (md_busy !== 1'b0 || stall_cnt !== 16'd0)
         $display("FAIL reset_mid: busy %b cnt %h, want busy 0 cnt 0000", md_busy, stall_cnt);
      else pass_count++;
      ex_mul_div = 0;
      #1;
      rst_n = 1'b1;
      #1;
      check_count++;
      if (dut_o !== DEF) $display("FAIL reset_release: got %b want %b", dut_o, DEF);
      else pass_count++;
      tick();
   endtask

   task automatic test_random();
      logic [6:0] exp;
      int np;
      int bad = 0;
      for (int i = 0; i < 400; i++) begin
         id_rs       = 5'($urandom_range(0, 3));
         id_rt       = 5'($urandom_range(0, 3));
         ex_reg      = 5'($urandom_range(0, 3));
         id_uses_rs  = 1'($urandom);
         id_uses_rt  = 1'($urandom);
         ex_mem_read = 1'($urandom);
         ex_br_taken = ($urandom_range(0, 3) == 0);
         ex_mul_div  = ($urandom_range(0, 15) == 0);
         cnt_clr     = ($urandom_range(0, 31) == 0);
         #3;
         exp = model_out(np);
         check_count++;
         if (dut_o !== exp || stall_cnt !== model_cnt) begin
            if (bad < 10)
               $display("FAIL random_%0d: out %b cnt %h, want %b cnt %h",
                        i, dut_o, stall_cnt, exp, model_cnt);
            bad++;
         end else pass_count++;
         tick();
      end
      set_idle();
   endtask

   task automatic test_saturation();
      set_idle();
      cnt_clr = 1;
      tick();
      cnt_clr = 0;
      set_hazard();
      repeat (65534) tick();
      check_count++;
      if (stall_cnt !== 16'hFFFE) $display("FAIL sat_preload: got %h want fffe", stall_cnt);
      else pass_count++;
      repeat (3) tick();
      check_count++;
      if (stall_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", stall_cnt);
      else pass_count++;
      cnt_clr = 1;
      #3;
      check_count++;
      if (pc_wr !== 1'b0) $display("FAIL clr_stall: pc_wr %b want 0", pc_wr);
      else pass_count++;
      tick();
      check_count++;
      if (stall_cnt !== 16'd0) $display("FAIL clr_wins: got %h want 0000", stall_cnt);
      else pass_count++;
      set_idle();
      tick();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_zero_reg();
      test_branch_load_use();
      test_muldiv();
      test_reset_mid_stall();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 The block SHALL take parameter MD_CYCLES, default 8, the number of cycles a mul/div occupies EX; legal range is 2..15.
REQ-002 Port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Ports ID_rs and ID_rt, input, 5 bits each: the source register numbers of the instruction in ID.
REQ-005 Ports ID_UsesRs and ID_UsesRt, input, 1 bit each: the ID instruction actually reads rs / rt.
REQ-006 Ports EX_MemRead (1 bit) and EX_Reg (5 bits), input: the EX instruction is a load, and its destination register.
REQ-007 Port EX_BrTaken, input, 1 bit: a branch or jump resolved taken in EX.
REQ-008 Port EX_MulDiv, input, 1 bit: the EX instruction is a multi-cycle mul/div.
REQ-009 Port Cnt_Clr, input, 1 bit: synchronous clear of the stall counter.
REQ-010 Ports PC_Wr, IFID_Wr and IDEX_Wr, output, 1 bit each: write enables for the PC, IF/ID and ID/EX registers.
REQ-011 Ports IFID_Flush, IDEX_Flush and EXMEM_Flush, output, 1 bit each: load a bubble into the named pipeline register.
REQ-012 Port MD_Busy, output, 1 bit: the FSM is in state MD_WAIT.
REQ-013 Port Stall_Cnt, output, 16 bits: saturating count of stalled cycles.

Function
REQ-014 The FSM SHALL have two states, RUN and MD_WAIT, plus a 4-bit down-counter md_cnt; all outputs are combinational from state, md_cnt and the inputs in the same cycle.
REQ-015 A load-use hazard SHALL be detected as EX_MemRead=1 and EX_Reg!=0 and ((ID_UsesRs=1 and EX_Reg=ID_rs) or (ID_UsesRt=1 and EX_Reg=ID_rt)).
REQ-016 In RUN with no event, outputs SHALL be: all write enables=1, all flushes=0.
REQ-017 The priority in RUN SHALL be: EX_MulDiv > EX_BrTaken > load-use.
REQ-018 A load-use hazard in RUN (no higher-priority event) SHALL drive PC_Wr=0, IFID_Wr=0 and IDEX_Flush=1 for exactly that cycle, with no state change; the forwarding unit covers the next cycle.
REQ-019 EX_BrTaken in RUN (no EX_MulDiv) SHALL drive IFID_Flush=1 and IDEX_Flush=1 with PC_Wr=1; any simultaneous load-use hazard is ignored because that instruction is wrong-path.
REQ-020 EX_MulDiv in RUN SHALL drive PC_Wr=0, IFID_Wr=0, IDEX_Wr=0 and EXMEM_Flush=1, load md_cnt<=MD_CYCLES-2, and move the FSM to MD_WAIT.
REQ-021 In MD_WAIT with md_cnt!=0, the block SHALL hold the same stall outputs as REQ-020 and decrement md_cnt; all other inputs are ignored.
REQ-022 In MD_WAIT with md_cnt==0, the block SHALL drive the RUN default outputs (release cycle) and move to RUN; load-use and branch are evaluated in that cycle as in RUN.
REQ-023 Mul/div timing: the instruction occupies EX for exactly MD_CYCLES cycles, of which MD_CYCLES-1 are stalled; with MD_CYCLES=2, MD_WAIT lasts one cycle and is itself the release cycle.
REQ-024 A cycle SHALL count as stalled when PC_Wr=0.
REQ-025 Stall_Cnt SHALL increment by 1 on every stalled cycle and saturate at 0xFFFF.
REQ-026 Cnt_Clr=1 SHALL set Stall_Cnt to 0 on the next edge and SHALL win over a simultaneous increment.

Reset
REQ-027 Rst_n=0 SHALL immediately force state=RUN, md_cnt=0 and Stall_Cnt=0, regardless of Clk.
REQ-028 Reset asserted mid-MD_WAIT SHALL abandon the mul/div stall; after release, outputs are the RUN defaults subject to current inputs.

Configuration
REQ-029 With macro MULDIV_STALL_EN defined, REQ-020..REQ-023 apply.
REQ-030 Without MULDIV_STALL_EN, EX_MulDiv SHALL be ignored, MD_WAIT and md_cnt SHALL not be built, MD_Busy SHALL be tied 0, and EXMEM_Flush SHALL be tied 0.

Structure
REQ-031 The state encoding (RUN=1'b0, MD_WAIT=1'b1) and the default MD_CYCLES SHALL live in the shared pipeline package, alongside the forwarding-select constants.
REQ-032 The combinational load-use comparator SHALL be a sub-module, load_use_detect; the FSM and counters stay in the top module.

Verification
REQ-033 Load-use: EX_MemRead=1, EX_Reg=5, ID_rs=5, ID_UsesRs=1 for one cycle -> PC_Wr=0, IFID_Wr=0, IDEX_Flush=1 that cycle only; Stall_Cnt 0->1.
REQ-034 Zero register: the same stimulus with EX_Reg=0 and ID_rs=0 -> no stall, all enables=1.
REQ-035 Branch plus load-use: EX_BrTaken=1 in the same cycle as the REQ-033 hazard -> IFID_Flush=1, IDEX_Flush=1, PC_Wr=1; Stall_Cnt unchanged.
REQ-036 Mul/div: MD_CYCLES=8, EX_MulDiv=1 at cycle t -> PC_Wr=0 and EXMEM_Flush=1 for cycles t..t+6, MD_Busy=1 for t+1..t+7, release at t+7; Stall_Cnt +7.
REQ-037 Reset mid-stall: Rst_n pulsed low at t+3 of REQ-036 -> MD_Busy=0 and Stall_Cnt=0 immediately; RUN defaults after release.
REQ-038 Saturation and clear: preload Stall_Cnt=0xFFFE, stall 3 cycles -> 0xFFFF; Cnt_Clr=1 together with a stall -> 0.
